bw_mul_seq: RTL and testbench

- Iterative, parametrised Baugh-Wooley multiplier; next generation after the combinational 16-bit Baugh-Wooley array.
- Retires one partial-product row per clock, so area scales with WIDTH rather than WIDTH^2.
- Adds a runtime signed/unsigned mode and valid/ready handshakes on both input and output.
- Used where multiply throughput is low and a full array is too large.

---
 rtl/bw_mul_seq.sv | 126 ++++++++++++
 tb/tb_bw_mul_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bw_mul_seq.sv
// Iterative Baugh-Wooley multiplier: one partial-product row is folded into the
// accumulator per clock, so a WIDTH x WIDTH product takes WIDTH cycles.
// A runtime mode selects two's-complement or unsigned operands.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    operands and mode presented
//   in_ready    block can accept operands (IDLE and not in reset)
//   x, y        multiplicand / multiplier, WIDTH bits
//   signed_mode 1: two's complement, 0: unsigned; sampled at accept
//   out_valid   p holds a completed product
//   out_ready   downstream accepts p
//   p           product, 2*WIDTH bits; holds last product after handoff
//   busy        high while calculating or holding a result
module bw_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  // One extra bit so the counter cannot wrap before the DONE transition.
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastRow = CW'(WIDTH - 1);
  // Baugh-Wooley correction constants 2^W + 2^(2W-1).
  localparam logic [PW-1:0] BwConst = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            y_bit;
  logic            last_row;
  logic [WIDTH-1:0] row_bits;
  logic [PW-1:0]   row_val;
  logic [PW-1:0]   row_sum;

  // Row cnt of the partial-product array, with sign-term inversion in signed mode.
  always_comb begin
    y_bit    = |(y_q & (WIDTH'(1) << cnt_q));
    last_row = (cnt_q == LastRow);
    row_bits = '0;
    for (int j = 0; j < WIDTH; j++) begin
      // Invert x_{W-1}*y_i (i<W-1) and x_j*y_{W-1} (j<W-1); the corner term stays plain.
      row_bits[j] = (x_q[j] & y_bit) ^ (mode_q & ((j == WIDTH - 1) != last_row));
    end
    row_val = {{WIDTH{1'b0}}, row_bits} << cnt_q;
    row_sum = acc_q + row_val + ((mode_q && (cnt_q == '0)) ? BwConst : '0);
  end

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign p         = p_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          x_d     = x;
          y_d     = y;
          mode_d  = signed_mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = row_sum;
        cnt_d = cnt_q + CW'(1);
        if (last_row) begin
          p_d     = row_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bw_mul_seq.sv
module tb_bw_mul_seq;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;
  logic          busy;

  int checks;
  int errors;

  bw_mul_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, wait for the product, check latency and value, hand it off.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [2*W-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    x = a;
    y = b;
    signed_mode = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = ~a;
    y = ~b;
    signed_mode = ~m;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(W));
    check({tag, " p"}, 64'(p), 64'(exp));
    out_ready = 1'b1;
    tick();
    check({tag, " handoff in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " handoff p held"}, 64'(p), 64'(exp));
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           m;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    int v;
    logic seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    signed_mode = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{16'h0002, 16'h0002, 1'b1, 32'h0000_0004};
    vecs[1] = '{16'hFE70, 16'h0002, 1'b1, 32'hFFFF_FCE0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[6] = '{16'h8000, 16'h0002, 1'b0, 32'h0001_0000};
    vecs[7] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF};
    vecs[8] = '{16'h1234, 16'h00FF, 1'b0, 32'h0012_21CC};

    #2;
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst p", 64'(p), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post rst in_ready", 64'(in_ready), 64'd1);

    // First op: in_ready stays low while the result is held.
    x = 16'd2;
    y = 16'd2;
    signed_mode = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("calc busy", 64'(busy), 64'd1);
    check("calc in_ready", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("first latency", 64'(n), 64'd16);
    check("first p", 64'(p), 64'h4);
    check("done in_ready", 64'(in_ready), 64'd0);
    tick();
    check("first out_valid dropped", 64'(out_valid), 64'd0);
    check("first in_ready back", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i));

    // Signed sweep: 2, 12 .. 52, then 52-100 .. 52-500, times 2.
    v = 2;
    for (int k = 0; k < 11; k++) begin
      run_op(16'(v), 16'd2, 1'b1, 32'(v * 2), $sformatf("sweep%0d", k));
      v = (k < 5) ? v + 10 : v - 100;
    end

    // Interference during CALC, then backpressure in DONE.
    x = 16'd100;
    y = 16'd7;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    x = 16'hFFFD;
    y = 16'd5;
    signed_mode = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("busy in_ready", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("intf latency", 64'(n), 64'd12);
    for (int k = 0; k < 20; k++) begin
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall p", 64'(p), 64'd700);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall handoff out_valid", 64'(out_valid), 64'd0);
    // Held in_valid now accepts the second op (-3 * 5 signed).
    check("second in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("second latency", 64'(n), 64'd16);
    check("second p", 64'(p), 64'hFFFF_FFF1);
    tick();

    // Reset after 8 CALC cycles aborts the op.
    x = 16'd9;
    y = 16'd9;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort p", 64'(p), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("no out_valid after abort", 64'(seen), 64'd0);
    check("abort release in_ready", 64'(in_ready), 64'd1);
    run_op(16'd3, 16'hFFFD, 1'b1, 32'hFFFF_FFF7, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
